// File: rtl/multi_channel_frequency_counter.sv
// multi_channel_frequency_counter: gated rising-edge counter for CHANNELS async inputs with Wishbone classic readout.
// Optional feature macro FREQ_COUNT_IRQ_EN: builds the DONE completion interrupt and a writable CTRL.IRQ_EN bit.
module multi_channel_frequency_counter #(
    parameter int          CHANNELS     = 4,
    parameter int          CNT_W        = 32,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [31:0] GATE_DEFAULT = 32'd1000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [7:0]          addr_i,
    input  logic [31:0]         dat_i,
    output logic [31:0]         dat_o,
    input  logic                we_i,
    input  logic [3:0]          sel_i,
    input  logic                cyc_i,
    input  logic                stb_i,
    output logic                ack_o,
    output logic                err_o,
    input  logic [CHANNELS-1:0] signal_i,
    output logic                irq_o
);
    typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_t;

    state_t              state, state_next;
    logic [CHANNELS-1:0] sync [SYNC_STAGES];
    logic [CHANNELS-1:0] prev, pulse, en, ovf;
    logic [CNT_W-1:0]    cnt [CHANNELS];
    logic [CNT_W-1:0]    result [CHANNELS];
    logic [31:0]         gate_len, timer, meas_cnt, gate_new, rdata;
    logic                cont, irq_en, done, access, bad, wr, ctrl_wr, status_wr, clr, start;

    assign access    = cyc_i & stb_i & ~ack_o & ~err_o;
    assign wr        = access & we_i & ~bad;
    assign ctrl_wr   = wr && addr_i == 8'h00;
    assign status_wr = wr && addr_i == 8'h01;
    assign clr       = ctrl_wr & sel_i[0] & dat_i[0];
    assign start     = ctrl_wr & sel_i[0] & dat_i[1] & ~dat_i[0];

    // Address decode, byte-merged GATE write value and read-data mux
    always_comb begin
        gate_new = gate_len;
        for (int b = 0; b < 4; b++) if (sel_i[b]) gate_new[8*b +: 8] = dat_i[8*b +: 8];
        rdata = '0;
        bad   = 1'b1;
        if (addr_i == 8'h00) begin
            rdata[2]             = cont;
            rdata[3]             = irq_en;
            rdata[16 +: CHANNELS] = en;
            bad                  = 1'b0;
        end
        if (addr_i == 8'h01) begin
            rdata[0]             = state != IDLE;
            rdata[1]             = done;
            rdata[8 +: CHANNELS] = ovf;
            bad                  = 1'b0;
        end
        if (addr_i == 8'h02) begin
            rdata = gate_len;
            bad   = we_i && gate_new == 32'd0;
        end
        for (int n = 0; n < CHANNELS; n++) if (addr_i == 8'(4 + n)) begin
            rdata = 32'(result[n]);
            bad   = we_i;
        end
        if (addr_i == 8'h10) begin
            rdata = meas_cnt;
            bad   = we_i;
        end
    end

    // Registered single-cycle bus response; read data captured on the acknowledging edge
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= access & ~bad;
            err_o <= access & bad;
            dat_o <= (access & ~we_i & ~bad) ? rdata : '0;
        end

    // Per-channel synchroniser followed by a registered rising-edge pulse
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync[s] <= '0;
            prev  <= '0;
            pulse <= '0;
        end else begin
            sync[0] <= signal_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync[s] <= sync[s-1];
            prev  <= sync[SYNC_STAGES-1];
            pulse <= sync[SYNC_STAGES-1] & ~prev;
        end

    // Software-visible control fields
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            gate_len <= GATE_DEFAULT;
            cont     <= 1'b0;
            en       <= '1;
        end else begin
            if (ctrl_wr && sel_i[0]) cont <= dat_i[2];
            if (ctrl_wr && sel_i[2]) en <= dat_i[16 +: CHANNELS];
            if (wr && addr_i == 8'h02) gate_len <= gate_new;
        end

    // Measurement state register
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) state <= IDLE;
        else state <= state_next;

    // Next-state logic; CLR overrides everything and START is only seen in IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ARM;
            ARM:     state_next = GATE;
            GATE:    if (timer == 32'd1) state_next = LATCH;
            LATCH:   if (cont) state_next = ARM; else state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clr) state_next = IDLE;
    end

    // Gate timer, live counters with saturation, result latch and status flags
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            timer    <= '0;
            ovf      <= '0;
            done     <= 1'b0;
            meas_cnt <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]    <= '0;
                result[i] <= '0;
            end
        end else if (clr) begin
            ovf  <= '0;
            done <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]    <= '0;
                result[i] <= '0;
            end
        end else begin
            if (state == ARM) timer <= gate_len;
            else if (state == GATE) timer <= timer - 32'd1;
            if (status_wr && sel_i[1]) ovf <= ovf & ~dat_i[8 +: CHANNELS];
            if (status_wr && sel_i[0] && dat_i[1]) done <= 1'b0;
            if (state == LATCH) begin
                done     <= 1'b1;
                meas_cnt <= meas_cnt + 32'd1;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (state == ARM) cnt[i] <= '0;
                else if (state == GATE && en[i] && pulse[i]) begin
                    if (cnt[i] == '1) ovf[i] <= 1'b1;
                    else cnt[i] <= cnt[i] + CNT_W'(1);
                end
                if (state == LATCH) result[i] <= en[i] ? cnt[i] : '0;
            end
        end

`ifdef FREQ_COUNT_IRQ_EN
    // Interrupt enable bit and registered level interrupt
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (ctrl_wr && sel_i[0]) irq_en <= dat_i[3];
            irq_o <= done & irq_en;
        end
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif
endmodule

// File: doc/multi_channel_frequency_counter.md
# multi_channel_frequency_counter

- Parametrised successor to the single-input `frequency_counter`.
- Counts rising edges on `CHANNELS` asynchronous signal inputs over a common programmable gate window, timed in `clk_i` cycles.
- Latches per-channel results for readout over a Wishbone classic slave port.
- Supports single-shot and continuous measurement, per-channel enables, saturation with overflow flags, and an optional completion interrupt.

## Interface
- `CHANNELS`, default 4: number of signal inputs, legal range 1..8.
- `CNT_W`, default 32: per-channel counter and result width, legal range 8..32.
- `SYNC_STAGES`, default 2: synchroniser depth per input, minimum 2.
- `GATE_DEFAULT`, default 1000: reset value of the GATE register.
- `clk_i`  in  1: sole clock; all logic on its rising edge.
- `rst_i`  in  1: reset, **asynchronous, active-low**.
- `addr_i`  in  8: register index (one 32-bit register per index).
- `dat_i`  in  32: write data.
- `dat_o`  out  32: read data, valid while `ack_o` is high.
- `we_i`  in  1: 1 = write, 0 = read.
- `sel_i`  in  4: byte enables for writes; byte k = `dat_i[8k+7:8k]`.
- `cyc_i`, `stb_i`  in  1 each: bus cycle and strobe.
- `ack_o`  out  1: access completed.
- `err_o`  out  1: access rejected.
- `signal_i`  in  CHANNELS: asynchronous inputs to be measured.
- `irq_o`  out  1: level interrupt (see Configuration).

## Operation
Register map (unused bits read 0):
- 0x00 CTRL
  - bit0 CLR, write-1, self-clearing.
  - bit1 START, write-1, self-clearing.
  - bit2 CONT (continuous mode).
  - bit3 IRQ_EN.
  - [23:16] channel enable mask; bits at or above CHANNELS are read-only 0. Reset value: all implemented channels enabled.
- 0x01 STATUS
  - bit0 BUSY, read-only.
  - bit1 DONE, sticky, write-1-to-clear.
  - [15:8] per-channel OVF, sticky, write-1-to-clear.
- 0x02 GATE: gate length in `clk_i` cycles, 32 bits. Writing 0 is rejected with `err_o`; the register is unchanged.
- 0x04+n RESULT[n], n < CHANNELS: read-only, zero-extended to 32 bits.
- 0x10 MEAS_CNT: completed-measurement count, 32 bits, read-only, wraps at 2^32.
- Any other index, any write to a read-only register, or an index ≥ 0x04+CHANNELS in the RESULT range: `err_o` instead of `ack_o`, no state change.

Input path, per channel:
- `SYNC_STAGES`-flop synchroniser feeding a rising-edge detector.
- A one-cycle edge pulse follows each sampled 0→1.
- Input frequency must be below f(`clk_i`)/2.

State machine:
- IDLE → ARM on START.
- ARM: 1 cycle. Clears live counters and the gate timer; loads the timer with GATE.
- GATE: exactly GATE cycles. Each enabled channel increments on every edge pulse in these cycles. At all-ones the counter saturates and sets that channel's OVF.
- LATCH: 1 cycle. Copies every live counter to RESULT (disabled channels latch 0), sets DONE, increments MEAS_CNT. Next state: ARM if CONT = 1, otherwise IDLE.
- BUSY = 1 in ARM, GATE and LATCH.

Boundary rules:
- START while BUSY: ignored.
- CLR in any state:
  - Forces IDLE on the next cycle.
  - Zeroes live counters, RESULT[], OVF and DONE.
  - Leaves MEAS_CNT, GATE and CTRL fields unchanged.
  - Does not set DONE.
- CLR and START in the same write: CLR wins; START is discarded.
- CONT cleared during GATE: the current gate completes and latches, then IDLE.
- GATE written during a measurement: takes effect at the next ARM.
- Enable mask changed mid-gate: takes effect on the next cycle.
- DONE write-1-to-clear in the same cycle as LATCH: the set wins.

## Timing
- Reset values:
  - `ack_o` = `err_o` = `irq_o` = 0; `dat_o` = 0.
  - State IDLE; all counters, RESULT[] and MEAS_CNT = 0.
  - GATE = `GATE_DEFAULT`; CONT = 0, IRQ_EN = 0.
- Bus access:
  - `ack_o`/`err_o` is registered and asserted one cycle after the sampled condition `cyc_i & stb_i & !ack_o & !err_o`, high for exactly 1 cycle.
  - A write takes effect on the same edge that raises `ack_o`.
  - A read returns the register value sampled on that edge.
- Edge latency: a `signal_i` rise to its edge pulse takes `SYNC_STAGES`+1 cycles.
- Measurement latency: START write-ack to DONE = 1 (ARM) + GATE + 1 (LATCH) cycles.
- Results are updated atomically on the LATCH edge; a RESULT read never returns a partial update.

## Configuration
- `FREQ_COUNT_IRQ_EN` defined:
  - `irq_o` = DONE & IRQ_EN, registered.
  - IRQ_EN is writable.
- Undefined:
  - `irq_o` is tied to 0.
  - CTRL bit3 reads 0 and ignores writes.
  - No interrupt logic is synthesised.

## Test plan
- **Reset:** hold `rst_i` low mid-GATE, release → all outputs 0, STATUS = 0, GATE reads 1000, RESULT[0..3] = 0, MEAS_CNT = 0.
- **Single shot:** `signal_i[0]` toggles synchronously every 4 cycles (period 8); GATE = 80, START → after 82 cycles DONE = 1, BUSY = 0, RESULT[0] = 10, RESULT[1..3] = 0, MEAS_CNT = 1.
- **Overflow:** CNT_W = 8, GATE = 4000, period 8 → RESULT[0] = 255, STATUS[8] = 1; writing 0x100 to STATUS clears it.
- **Continuous:** CONT = 1, GATE = 80, period 8, then period 16 after the first LATCH → successive RESULT[0] reads 10 then 5; clearing CONT stops after the current gate; MEAS_CNT increments once per gate.
- **Bus errors:** write GATE = 0 → `err_o` for 1 cycle, GATE unchanged; read index 0x03 → `err_o`; write to RESULT[0] → `err_o`.
- **Clear mid-gate:** CLR 20 cycles into GATE → BUSY = 0 next cycle, DONE stays 0, RESULT[] = 0; with `FREQ_COUNT_IRQ_EN` and IRQ_EN = 1, `irq_o` stays 0.
